// File: rtl/nios_ii_system_lfsr_gen.sv
// nios_ii_system_lfsr_gen
// Avalon-MM (s1) controlled 5-bit Fibonacci LFSR that feeds the CPU-side input
// PIO. The CPU seeds the generator, sets a prescaler and runs it free-running,
// single-stepped or for a counted burst. out_port is always a register output.
module nios_ii_system_lfsr_gen #(
  parameter int unsigned      WIDTH    = 5,
  parameter logic [WIDTH-1:0] TAPS     = 5'b10100,
  parameter logic [WIDTH-1:0] SEED_RST = 5'b00001,
  parameter int unsigned      DIV_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             step_pulse
);

  // Register map word addresses
  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_CTRL  = 2'd1;
  localparam logic [1:0] ADDR_DIV   = 2'd2;
  localparam logic [1:0] ADDR_BURST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FREE  = 2'd1,
    ST_BURST = 2'd2
  } fsm_e;

  // Next LFSR value: shift left, feedback is the parity of the tapped bits.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  // An all-zero state would lock the LFSR forever, so a zero seed becomes 1.
  function automatic logic [WIDTH-1:0] seed_guard(input logic [WIDTH-1:0] v);
    return (v == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : v;
  endfunction

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [15:0]      rem_q, rem_d;
  logic             step_req_q, step_req_d;
  logic             step_pulse_q, step_pulse_d;
  logic [31:0]      readdata_q, readdata_d;

  logic        wr;
  logic        wr_data, wr_ctrl, wr_div, wr_burst;
  logic [15:0] burst_n;
  logic        tick;
  logic        step_en;
  logic        busy;
  logic        run;
  logic        unused_wdata;

  assign wr       = chipselect & ~write_n;
  assign wr_data  = wr && (address == ADDR_DATA);
  assign wr_ctrl  = wr && (address == ADDR_CTRL);
  assign wr_div   = wr && (address == ADDR_DIV);
  assign wr_burst = wr && (address == ADDR_BURST);
  assign burst_n  = writedata[15:0];

  // Upper write-data bits carry no register field.
  assign unused_wdata = ^writedata[31:16];

  assign busy = (fsm_q == ST_BURST);
  assign run  = (fsm_q == ST_FREE);

  // Prescaler tick: only meaningful while stepping autonomously.
  assign tick = (fsm_q != ST_IDLE) && (div_cnt_q == div_q);

  // Next-state logic: FSM, prescaler, LFSR update, burst count and read mux.
  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    div_d        = div_q;
    rem_d        = rem_q;
    step_req_d   = 1'b0;
    step_en      = 1'b0;
    readdata_d   = '0;

    // Counter free-runs 0..DIV while stepping, parked at 0 in IDLE.
    if (fsm_q == ST_IDLE || tick) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    unique case (fsm_q)
      ST_IDLE: begin
        // A STEP request latched last cycle is executed now.
        if (step_req_q) begin
          step_en = 1'b1;
        end
        if (wr_ctrl && writedata[0]) begin
          fsm_d     = ST_FREE;
          div_cnt_d = '0;
        end else if (wr_ctrl && writedata[1]) begin
          step_req_d = 1'b1;
        end else if (wr_burst && (burst_n != 16'd0)) begin
          fsm_d     = ST_BURST;
          rem_d     = burst_n;
          div_cnt_d = '0;
        end
      end
      ST_FREE: begin
        // Stopping wins over a coincident tick.
        if (wr_ctrl && !writedata[0]) begin
          fsm_d     = ST_IDLE;
          div_cnt_d = '0;
        end else if (tick) begin
          step_en = 1'b1;
        end
      end
      ST_BURST: begin
        // Writing a zero count aborts; RUN writes have no effect here.
        if (wr_burst && (burst_n == 16'd0)) begin
          fsm_d     = ST_IDLE;
          rem_d     = 16'd0;
          div_cnt_d = '0;
        end else if (tick) begin
          step_en = 1'b1;
        end
      end
      default: begin
        fsm_d     = ST_IDLE;
        div_cnt_d = '0;
      end
    endcase

    // A seed write takes the cycle: any step due now is dropped.
    if (wr_data) begin
      state_d = seed_guard(writedata[WIDTH-1:0]);
      step_en = 1'b0;
    end else if (step_en) begin
      state_d = lfsr_next(state_q);
    end

    // Burst accounting only counts steps that actually happened.
    if (fsm_q == ST_BURST && step_en) begin
      rem_d = rem_q - 16'd1;
      if (rem_q == 16'd1) begin
        fsm_d     = ST_IDLE;
        div_cnt_d = '0;
      end
    end

    // A new divider restarts the count from zero.
    if (wr_div) begin
      div_d     = writedata[DIV_W-1:0];
      div_cnt_d = '0;
    end

    step_pulse_d = step_en;

    unique case (address)
      ADDR_DATA:  readdata_d = {{(32-WIDTH){1'b0}}, state_q};
      ADDR_CTRL:  readdata_d = {31'd0, run};
      ADDR_DIV:   readdata_d = {{(32-DIV_W){1'b0}}, div_q};
      ADDR_BURST: readdata_d = {15'd0, busy, rem_q};
      default:    readdata_d = '0;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q        <= ST_IDLE;
      state_q      <= SEED_RST;
      div_q        <= '0;
      div_cnt_q    <= '0;
      rem_q        <= '0;
      step_req_q   <= 1'b0;
      step_pulse_q <= 1'b0;
      readdata_q   <= '0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      div_q        <= div_d;
      div_cnt_q    <= div_cnt_d;
      rem_q        <= rem_d;
      step_req_q   <= step_req_d;
      step_pulse_q <= step_pulse_d;
      readdata_q   <= readdata_d;
    end
  end

  assign out_port   = state_q;
  assign step_pulse = step_pulse_q;
  assign readdata   = readdata_q;

endmodule

// File: tb/tb_nios_ii_system_lfsr_gen.sv
// Directed testbench for nios_ii_system_lfsr_gen.
module tb_nios_ii_system_lfsr_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [4:0]  out_port;
  logic        step_pulse;

  int vectors     = 0;
  int miscompares = 0;

  nios_ii_system_lfsr_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  function automatic logic [4:0] model_next(input logic [4:0] s);
    return {s[3:0], s[4] ^ s[2]};
  endfunction

  logic [4:0]  exp_steps [4] = '{5'h02, 5'h04, 5'h09, 5'h12};
  logic [31:0] seen;
  logic [4:0]  prev;
  int          pulses;
  int          last;

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;

    // 1: reset state
    tick();
    tick();
    chk("rst_out_port", 32'(out_port), 32'h01);
    chk("rst_step_pulse", 32'(step_pulse), 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    address = 2'd0;
    tick();
    chk("rd_data_after_rst", readdata, 32'h1);
    address = 2'd1;
    tick();
    chk("rd_ctrl_after_rst", readdata, 32'h0);
    address = 2'd3;
    tick();
    chk("rd_burst_after_rst", readdata, 32'h0);
    chk("idle_no_pulse", 32'(step_pulse), 32'h0);

    // 2: four single steps
    for (int k = 0; k < 4; k++) begin
      wr(2'd1, 32'h2);
      chk("step_no_pulse_yet", 32'(step_pulse), 32'h0);
      tick();
      chk("step_out_port", 32'(out_port), 32'(exp_steps[k]));
      chk("step_pulse_hi", 32'(step_pulse), 32'h1);
      tick();
      chk("step_pulse_lo", 32'(step_pulse), 32'h0);
    end

    // 3: free run at DIV=0 through the full period
    wr(2'd0, 32'h1);
    wr(2'd2, 32'h0);
    wr(2'd1, 32'h1);
    chk("run_entry_no_pulse", 32'(step_pulse), 32'h0);
    seen = 32'd0;
    prev = 5'h01;
    for (int i = 0; i < 31; i++) begin
      tick();
      chk("run_pulse", 32'(step_pulse), 32'h1);
      chk("run_seq", 32'(out_port), 32'(model_next(prev)));
      chk("run_nonzero", 32'(out_port != 5'd0), 32'h1);
      chk("run_distinct", 32'(seen[out_port]), 32'h0);
      seen[out_port] = 1'b1;
      prev = out_port;
    end
    chk("run_period", 32'(out_port), 32'h01);
    wr(2'd1, 32'h0);
    chk("stop_no_step_out", 32'(out_port), 32'h01);
    chk("stop_no_step_pulse", 32'(step_pulse), 32'h0);

    // 4: burst of 10 at DIV=3
    wr(2'd2, 32'h3);
    wr(2'd3, 32'd10);
    address = 2'd3;
    pulses  = 0;
    last    = 0;
    for (int i = 1; i <= 48; i++) begin
      tick();
      if (i == 1) chk("burst_busy_rem", readdata, 32'h0001_000A);
      if (step_pulse) begin
        pulses++;
        chk("burst_spacing", 32'(i - last), 32'd4);
        last = i;
      end
    end
    chk("burst_count", 32'(pulses), 32'd10);
    chk("burst_done_rd", readdata, 32'h0);
    chk("burst_final_state", 32'(out_port), 32'h13);

    // 5: zero-seed guard and seed write landing on a tick
    wr(2'd0, 32'h0);
    chk("seed0_out", 32'(out_port), 32'h01);
    address = 2'd0;
    tick();
    chk("seed0_rd", readdata, 32'h1);
    wr(2'd1, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("run_div3_quiet", 32'(step_pulse), 32'h0);
    end
    wr(2'd0, 32'h15);
    chk("seed_on_tick_out", 32'(out_port), 32'h15);
    chk("seed_on_tick_pulse", 32'(step_pulse), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("after_seed_quiet", 32'(step_pulse), 32'h0);
    end
    tick();
    chk("after_seed_step_pulse", 32'(step_pulse), 32'h1);
    chk("after_seed_step_out", 32'(out_port), 32'h0A);
    wr(2'd1, 32'h0);

    // 6: reset in the middle of a burst
    wr(2'd2, 32'h0);
    wr(2'd3, 32'd10);
    for (int i = 0; i < 5; i++) tick();
    chk("mid_burst_state", 32'(out_port), 32'h02);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_out", 32'(out_port), 32'h01);
    chk("mid_rst_pulse", 32'(step_pulse), 32'h0);
    reset_n = 1'b1;
    address = 2'd3;
    pulses  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (step_pulse) pulses++;
    end
    chk("post_rst_no_pulse", 32'(pulses), 32'd0);
    chk("post_rst_busy_rem", readdata, 32'h0);
    chk("post_rst_out", 32'(out_port), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
